// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART byte transmitter between two byte producers.
// Latches the winning byte, runs the start/busy handshake, then holds an inter-frame gap.
module uart_tx_scheduler #(
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 8,
  parameter int CNT_W        = 8
) (
  input  logic       i_uart_clk,
  input  logic       i_rst_n,
  input  logic       i_req0,
  input  logic [7:0] i_data0,
  input  logic       i_req1,
  input  logic [7:0] i_data1,
  input  logic       i_tx_busy,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_timeout_err,
  output logic       o_grant_id
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUSY_LIMIT = CNT_W'(BUSY_TIMEOUT);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ptr;
  logic [7:0]       r_tx_data;
  logic             r_tx_start;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_timeout_err;
  logic             r_grant_id;

  logic             w_any_req;
  logic             w_contend;
  logic             w_sel;
  logic             w_can_grant;
  logic [CNT_W-1:0] w_cnt_inc;

  // Arbitration: a lone requester wins outright, contention follows the pointer.
  always_comb begin
    w_any_req   = i_req0 | i_req1;
    w_contend   = i_req0 & i_req1;
    w_cnt_inc   = r_cnt + CNT_ONE;
    w_can_grant = w_any_req & ~i_tx_busy;
    if (w_contend) begin
      w_sel = r_ptr;
    end else if (i_req1) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
  end

  // Scheduler state, counter and every registered output.
  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= CNT_ZERO;
      r_ptr         <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_start    <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_grant_id    <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_can_grant) begin
            r_tx_data  <= w_sel ? i_data1 : i_data0;
            r_grant_id <= w_sel;
            r_tx_start <= 1'b1;
            r_cnt      <= CNT_ZERO;
            r_state    <= ST_START;
            if (w_contend) begin
              r_ptr <= ~w_sel;
            end
          end
        end
        // The counter measures cycles since tx_start, so the START cycle counts as one.
        ST_START: begin
          r_cnt   <= w_cnt_inc;
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (i_tx_busy) begin
            r_cnt   <= CNT_ZERO;
            r_state <= ST_SEND;
          end else if (w_cnt_inc == BUSY_LIMIT) begin
            r_timeout_err <= 1'b1;
            r_cnt         <= CNT_ZERO;
            r_state       <= ST_GAP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_SEND: begin
          if (!i_tx_busy) begin
            if (r_grant_id) begin
              r_ack1 <= 1'b1;
            end else begin
              r_ack0 <= 1'b1;
            end
            r_cnt   <= CNT_ZERO;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= CNT_ZERO;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_cnt   <= CNT_ZERO;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ack0        = r_ack0;
  assign o_ack1        = r_ack1;
  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_timeout_err = r_timeout_err;
  assign o_grant_id    = r_grant_id;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table of single-frame scenarios, hand-written corner
// sequences, and a randomized run against a timing-rule reference model.
module tb_uart_tx_scheduler;

  localparam int GAP = 16;
  localparam int TMO = 8;
  localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_SEND = 3, P_GAP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       man_busy, auto_busy;
  wire        tx_busy = man_busy | auto_busy;
  logic       ack0, ack1, tx_start, timeout_err, grant_id;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO), .CNT_W(8)) dut (
    .i_uart_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_data0(data0), .i_req1(req1), .i_data1(data1),
    .i_tx_busy(tx_busy),
    .o_ack0(ack0), .o_ack1(ack1), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .o_timeout_err(timeout_err), .o_grant_id(grant_id)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // transmitter model: answers tx_start with busy after a delay, for a length
  bit auto_en = 1'b0, auto_rand = 1'b0, auto_active = 1'b0;
  int auto_dly = 2, auto_len = 20;

  initial begin : auto_tx
    int d;
    int l;
    auto_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (auto_en && tx_start) begin
        auto_active = 1'b1;
        d = auto_rand ? int'($urandom_range(1, 10)) : auto_dly;
        l = auto_rand ? int'($urandom_range(1, 6)) : auto_len;
        repeat (d) @(posedge clk);
        #1 auto_busy = 1'b1;
        repeat (l) @(posedge clk);
        #1 auto_busy = 1'b0;
        auto_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [12:0] outs();
    return {tx_start, ack0, ack1, timeout_err, grant_id, tx_data};
  endfunction

  task automatic do_reset();
    auto_en  = 1'b0;
    req0     = 1'b0;
    req1     = 1'b0;
    man_busy = 1'b0;
    for (int i = 0; i < 64 && (auto_active || auto_busy); i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_start(input string nm);
    int i;
    i = 0;
    while (!tx_start && i < 300) begin
      tick();
      i++;
    end
    chk(nm, {31'd0, tx_start}, 32'd1);
  endtask

  // ---------------- table-driven single-frame scenarios ----------------
  // bdly/blen: busy driven high from cycle start+bdly for blen cycles (bdly<0: never).
  // Cycle numbers below are counted from the cycle tx_start is visible; a zero entry
  // means the event does not occur.
  typedef struct {
    bit r0; bit r1; logic [7:0] d0; logic [7:0] d1; int bdly; int blen;
    bit egid; logic [7:0] edata; int eack0; int eack1; int eack_cyc;
    int eto_cyc; int ere_cyc; logic [7:0] ere_data;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input int idx, input vec_t v);
    int n_a0, n_a1, ack_c, to_c, re_c;
    logic [7:0] re_d;
    n_a0 = 0; n_a1 = 0; ack_c = 0; to_c = 0; re_c = 0; re_d = 8'h00;
    do_reset();
    req0 = v.r0; req1 = v.r1; data0 = v.d0; data1 = v.d1;
    chk($sformatf("v%0d_no_comb_start", idx), {31'd0, tx_start}, 32'd0);
    tick();
    chk($sformatf("v%0d_start", idx), {31'd0, tx_start}, 32'd1);
    chk($sformatf("v%0d_gid", idx), {31'd0, grant_id}, {31'd0, v.egid});
    chk($sformatf("v%0d_data", idx), {24'd0, tx_data}, {24'd0, v.edata});
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (v.bdly >= 0) man_busy = (c >= v.bdly) && (c < v.bdly + v.blen);
      if (ack0) begin n_a0++; if (ack_c == 0) ack_c = c; req0 = 1'b0; end
      if (ack1) begin n_a1++; if (ack_c == 0) ack_c = c; req1 = 1'b0; end
      if (timeout_err && to_c == 0) to_c = c;
      if (tx_start && re_c == 0) begin re_c = c; re_d = tx_data; end
    end
    req0 = 1'b0; req1 = 1'b0; man_busy = 1'b0;
    chk($sformatf("v%0d_ack0_count", idx), n_a0, v.eack0);
    chk($sformatf("v%0d_ack1_count", idx), n_a1, v.eack1);
    chk($sformatf("v%0d_ack_cycle", idx), ack_c, v.eack_cyc);
    chk($sformatf("v%0d_timeout_cycle", idx), to_c, v.eto_cyc);
    chk($sformatf("v%0d_restart_cycle", idx), re_c, v.ere_cyc);
    chk($sformatf("v%0d_restart_data", idx), {24'd0, re_d}, {24'd0, v.ere_data});
  endtask

  // ---------------- reference model for the random run ----------------
  int         m_phase, m_left;
  bit         m_ptr, m_w;
  bit         e_start, e_ack0, e_ack1, e_to, e_gid;
  logic [7:0] e_data;
  bit         s_r0, s_r1, s_busy;
  logic [7:0] s_d0, s_d1;

  task automatic model_reset();
    m_phase = P_IDLE; m_left = 0; m_ptr = 1'b0;
    e_start = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0; e_to = 1'b0; e_gid = 1'b0;
    e_data = 8'h00;
  endtask

  // One clock of the timing rules: start one cycle after grant, timeout TMO cycles
  // after start, ack one cycle after busy seen low, then GAP idle cycles.
  task automatic model_step();
    e_start = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
    case (m_phase)
      P_IDLE: if (!s_busy && (s_r0 || s_r1)) begin
        m_w = (s_r0 && s_r1) ? m_ptr : s_r1;
        if (s_r0 && s_r1) m_ptr = !m_w;
        e_gid = m_w; e_data = m_w ? s_d1 : s_d0; e_start = 1'b1;
        m_phase = P_START;
      end
      P_START: begin m_phase = P_WAIT; m_left = TMO - 1; end
      P_WAIT: if (s_busy) m_phase = P_SEND;
              else begin
                m_left--;
                if (m_left == 0) begin e_to = 1'b1; m_phase = P_GAP; m_left = GAP; end
              end
      P_SEND: if (!s_busy) begin
        if (e_gid) e_ack1 = 1'b1; else e_ack0 = 1'b1;
        m_phase = P_GAP; m_left = GAP;
      end
      P_GAP: begin m_left--; if (m_left == 0) m_phase = P_IDLE; end
      default: m_phase = P_IDLE;
    endcase
  endtask

  initial begin : main
    logic [7:0] fexp;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00; man_busy = 1'b0;
    tick(); tick();
    chk("reset_state", {19'd0, outs()}, 32'd0);
    rst_n = 1'b1;
    tick();

    vt[0] = '{1, 0, 8'hA2, 8'h00,  2, 20, 0, 8'hA2, 1, 0, 23,  0,  0, 8'h00};
    vt[1] = '{0, 1, 8'h00, 8'h5C,  1,  3, 1, 8'h5C, 0, 1,  5,  0,  0, 8'h00};
    vt[2] = '{1, 1, 8'h86, 8'h92,  2,  5, 0, 8'h86, 1, 0,  8, 33, 25, 8'h92};
    vt[3] = '{1, 0, 8'h3C, 8'h00, -1,  0, 0, 8'h3C, 0, 0,  0,  8, 25, 8'h3C};
    vt[4] = '{0, 1, 8'h00, 8'hE7,  7,  4, 1, 8'hE7, 0, 1, 12,  0,  0, 8'h00};
    vt[5] = '{1, 0, 8'h11, 8'h00,  8,  4, 0, 8'h11, 0, 0,  0,  8, 25, 8'h11};
    vt[6] = '{1, 1, 8'h5A, 8'hA5, -1,  0, 0, 8'h5A, 0, 0,  0,  8, 25, 8'hA5};
    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // contention fairness: both held high, grants must alternate
    do_reset();
    auto_en = 1'b1; auto_rand = 1'b0; auto_dly = 2; auto_len = 20;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h86; data1 = 8'h92;
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("fair%0d_start", k));
      fexp = (k % 2 == 1) ? 8'h92 : 8'h86;
      chk($sformatf("fair%0d_gid", k), {31'd0, grant_id}, k % 2);
      chk($sformatf("fair%0d_data", k), {24'd0, tx_data}, {24'd0, fexp});
      tick();
    end

    // data change mid-frame must not reach tx_data
    do_reset();
    auto_en = 1'b1; auto_dly = 2; auto_len = 10;
    req1 = 1'b1; data1 = 8'h8A;
    wait_start("dc_start");
    chk("dc_data_grant", {24'd0, tx_data}, 32'h8A);
    repeat (5) tick();
    data1 = 8'h82;
    for (int i = 0; i < 40 && !ack1; i++) begin
      tick();
      if (!ack1) chk("dc_hold_data", {24'd0, tx_data}, 32'h8A);
    end
    chk("dc_ack1", {31'd0, ack1}, 32'd1);
    chk("dc_data_at_ack", {24'd0, tx_data}, 32'h8A);
    req1 = 1'b0;

    // timeout first, then asynchronous reset in the middle of a retried frame
    do_reset();
    req0 = 1'b1; data0 = 8'hC3;
    wait_start("rst_first_start");
    for (int i = 0; i < 40 && !timeout_err; i++) tick();
    chk("rst_pre_timeout", {31'd0, timeout_err}, 32'd1);
    auto_en = 1'b1; auto_dly = 2; auto_len = 20;
    wait_start("rst_retry_start");
    chk("rst_retry_data", {24'd0, tx_data}, 32'hC3);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", {19'd0, outs()}, 32'd0);
    req0 = 1'b0; req1 = 1'b1; data1 = 8'h4B;
    @(negedge clk);
    rst_n = 1'b1;
    wait_start("rst_after_start");
    chk("rst_after_gid", {31'd0, grant_id}, 32'd1);
    chk("rst_after_data", {24'd0, tx_data}, 32'h4B);
    req1 = 1'b0;

    // foreign frame on the line: no grant until busy drops
    do_reset();
    man_busy = 1'b1; req0 = 1'b1; data0 = 8'h29;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fb_no_start", {31'd0, tx_start}, 32'd0);
    end
    man_busy = 1'b0;
    tick();
    chk("fb_start", {31'd0, tx_start}, 32'd1);
    chk("fb_data", {24'd0, tx_data}, 32'h29);
    req0 = 1'b0;

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    auto_en = 1'b1; auto_rand = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (req0 && (ack0 || $urandom_range(0, 63) == 0)) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin req0 = 1'b1; data0 = 8'($urandom); end
      if (req1 && (ack1 || $urandom_range(0, 63) == 0)) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin req1 = 1'b1; data1 = 8'($urandom); end
      if (m_phase != P_IDLE && $urandom_range(0, 7) == 0) begin
        if (e_gid) data1 = 8'($urandom); else data0 = 8'($urandom);
      end
      @(negedge clk);
      s_r0 = req0; s_r1 = req1; s_d0 = data0; s_d1 = data1; s_busy = tx_busy;
      tick();
      model_step();
      chk("rand_outputs", {19'd0, outs()},
          {19'd0, e_start, e_ack0, e_ack1, e_to, e_gid, e_data});
    end
    req0 = 1'b0; req1 = 1'b0; auto_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
